// File: rtl/key_debouncer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : key_debouncer_pkg
//  Purpose  : Shared channel state encoding and counter sizing helper.
//  Revision : 1.0  initial release
// ============================================================================
package key_debouncer_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } key_state_t;

    // Width able to hold 0 .. max(a,b)-1, never narrower than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        int w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module   : key_debounce_channel
//  Purpose  : One key: two-flop synchroniser, debounce FSM, auto-repeat timer.
//  Revision : 1.0  initial release
// ============================================================================
module key_debounce_channel
    import key_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_EN       = 0,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_stable,
    output logic o_press,
    output logic o_release,
    output logic o_held
);

    localparam int c_cnt_w = cnt_width(DEBOUNCE_CYCLES, DEBOUNCE_CYCLES);
    localparam int c_rpt_w = cnt_width(HOLD_CYCLES, REPEAT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_rpt_w-1:0] c_hold_max = c_rpt_w'(HOLD_CYCLES - 1);
    localparam logic [c_rpt_w-1:0] c_rep_max  = c_rpt_w'(REPEAT_CYCLES - 1);
    localparam logic               c_rel_lvl  = (ACTIVE_LOW != 0);

    key_state_t         r_state;
    logic               r_sync1;
    logic               r_sync2;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_rpt_w-1:0] r_rpt;
    logic               r_first;
    logic               r_stable;
    logic               r_press;
    logic               r_release;
    logic               r_held;
    logic               w_p;

    assign w_p = r_sync2 ^ c_rel_lvl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= c_rel_lvl;
            r_sync2   <= c_rel_lvl;
            r_state   <= ST_RELEASED;
            r_cnt     <= '0;
            r_rpt     <= '0;
            r_first   <= 1'b1;
            r_stable  <= c_rel_lvl;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_sync1   <= i_raw;
            r_sync2   <= r_sync1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                ST_RELEASED: begin
                    if (w_p) begin
                        r_state <= ST_PRESS_WAIT;
                        r_cnt   <= '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!w_p) begin
                        r_state <= ST_RELEASED;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_max) begin
                        r_state  <= ST_PRESSED;
                        r_cnt    <= '0;
                        r_stable <= ~c_rel_lvl;
                        r_held   <= 1'b1;
                        r_press  <= 1'b1;
                        r_rpt    <= '0;
                        r_first  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    // The repeat timer only advances on cycles that are
                    // confirmed pressed; a release glitch just pauses it.
                    if (!w_p) begin
                        r_state <= ST_RELEASE_WAIT;
                        r_cnt   <= '0;
                    end else if (REPEAT_EN != 0) begin
                        if (r_rpt == (r_first ? c_hold_max : c_rep_max)) begin
                            r_press <= 1'b1;
                            r_rpt   <= '0;
                            r_first <= 1'b0;
                        end else begin
                            r_rpt <= r_rpt + 1'b1;
                        end
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (w_p) begin
                        r_state <= ST_PRESSED;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_max) begin
                        r_state   <= ST_RELEASED;
                        r_cnt     <= '0;
                        r_stable  <= c_rel_lvl;
                        r_held    <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_RELEASED;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_stable  = r_stable;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_held    = r_held;

endmodule
`default_nettype wire

// File: rtl/key_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : key_debouncer
//  Purpose  : NUM_KEYS independent debounce channels for the DE2 push keys.
//  Revision : 1.0  initial release
// ============================================================================
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_EN       = 0,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [NUM_KEYS-1:0] raw_in,
    output logic [NUM_KEYS-1:0] stable_out,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] held
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW),
            .REPEAT_EN       (REPEAT_EN),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_chan (
            .clk       (clk_clk),
            .rst_n     (reset_reset_n),
            .i_raw     (raw_in[i]),
            .o_stable  (stable_out[i]),
            .o_press   (press_pulse[i]),
            .o_release (release_pulse[i]),
            .o_held    (held[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_key_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_debouncer
//  Purpose  : Self-checking bench for key_debouncer against a run-length model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_key_debouncer;

    localparam int c_d = 8;
    localparam int c_h = 20;
    localparam int c_r = 6;
    localparam int c_nk[3]  = '{4, 4, 18};
    localparam int c_al[3]  = '{1, 1, 0};
    localparam int c_rep[3] = '{0, 1, 1};

    logic        clk;
    logic        rst_n;
    logic [3:0]  raw_a, raw_b;
    logic [17:0] raw_c;
    logic [3:0]  stable_a, press_a, rel_a, held_a;
    logic [3:0]  stable_b, press_b, rel_b, held_b;
    logic [17:0] stable_c, press_c, rel_c, held_c;

    key_debouncer #(.NUM_KEYS(4), .DEBOUNCE_CYCLES(c_d), .ACTIVE_LOW(1), .REPEAT_EN(0),
                    .HOLD_CYCLES(c_h), .REPEAT_CYCLES(c_r)) dut_a (
        .clk_clk(clk), .reset_reset_n(rst_n), .raw_in(raw_a),
        .stable_out(stable_a), .press_pulse(press_a), .release_pulse(rel_a), .held(held_a));

    key_debouncer #(.NUM_KEYS(4), .DEBOUNCE_CYCLES(c_d), .ACTIVE_LOW(1), .REPEAT_EN(1),
                    .HOLD_CYCLES(c_h), .REPEAT_CYCLES(c_r)) dut_b (
        .clk_clk(clk), .reset_reset_n(rst_n), .raw_in(raw_b),
        .stable_out(stable_b), .press_pulse(press_b), .release_pulse(rel_b), .held(held_b));

    key_debouncer #(.NUM_KEYS(18), .DEBOUNCE_CYCLES(c_d), .ACTIVE_LOW(0), .REPEAT_EN(1),
                    .HOLD_CYCLES(c_h), .REPEAT_CYCLES(c_r)) dut_c (
        .clk_clk(clk), .reset_reset_n(rst_n), .raw_in(raw_c),
        .stable_out(stable_c), .press_pulse(press_c), .release_pulse(rel_c), .held(held_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
        end
    endtask

    // Model: the debounced level flips once the synchronised level has
    // disagreed with it for DEBOUNCE_CYCLES+1 consecutive samples; repeats
    // count samples that are pressed and follow a pressed sample.
    bit m_s1[3][18], m_s2[3][18], m_pprev[3][18], m_pressed[3][18];
    bit m_first[3][18], m_press[3][18], m_rel[3][18];
    int m_run[3][18], m_rcnt[3][18];
    int pc_press[3][18], pc_rel[3][18];

    function automatic bit raw_bit(input int d, input int k);
        case (d)
            0:       return raw_a[k];
            1:       return raw_b[k];
            default: return raw_c[k];
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++)
            for (int k = 0; k < 18; k++) begin
                m_s1[d][k] = c_al[d][0]; m_s2[d][k] = c_al[d][0];
                m_pprev[d][k] = 0; m_pressed[d][k] = 0; m_first[d][k] = 1;
                m_press[d][k] = 0; m_rel[d][k] = 0;
                m_run[d][k] = 0; m_rcnt[d][k] = 0;
            end
    endtask

    task automatic model_edge();
        bit p;
        for (int d = 0; d < 3; d++)
            for (int k = 0; k < c_nk[d]; k++) begin
                p = m_s2[d][k] ^ c_al[d][0];
                m_s2[d][k] = m_s1[d][k];
                m_s1[d][k] = raw_bit(d, k);
                m_press[d][k] = 0;
                m_rel[d][k] = 0;
                if (p != m_pressed[d][k]) begin
                    m_run[d][k]++;
                    if (m_run[d][k] == c_d + 1) begin
                        m_pressed[d][k] = p;
                        m_run[d][k] = 0; m_rcnt[d][k] = 0; m_first[d][k] = 1;
                        if (p) m_press[d][k] = 1; else m_rel[d][k] = 1;
                    end
                end else begin
                    m_run[d][k] = 0;
                    if (c_rep[d] != 0 && m_pressed[d][k] && m_pprev[d][k]) begin
                        m_rcnt[d][k]++;
                        if (m_rcnt[d][k] == (m_first[d][k] ? c_h : c_r)) begin
                            m_press[d][k] = 1; m_rcnt[d][k] = 0; m_first[d][k] = 0;
                        end
                    end
                end
                m_pprev[d][k] = p;
            end
    endtask

    task automatic compare_all();
        logic [17:0] es, ep, er, eh, as_, ap, ar, ah;
        for (int d = 0; d < 3; d++) begin
            es = '0; ep = '0; er = '0; eh = '0;
            for (int k = 0; k < c_nk[d]; k++) begin
                es[k] = m_pressed[d][k] ^ c_al[d][0];
                ep[k] = m_press[d][k];
                er[k] = m_rel[d][k];
                eh[k] = m_pressed[d][k];
            end
            case (d)
                0:       begin as_ = {14'b0, stable_a}; ap = {14'b0, press_a}; ar = {14'b0, rel_a}; ah = {14'b0, held_a}; end
                1:       begin as_ = {14'b0, stable_b}; ap = {14'b0, press_b}; ar = {14'b0, rel_b}; ah = {14'b0, held_b}; end
                default: begin as_ = stable_c; ap = press_c; ar = rel_c; ah = held_c; end
            endcase
            check($sformatf("d%0d_stable", d), 32'(as_), 32'(es));
            check($sformatf("d%0d_press", d),  32'(ap),  32'(ep));
            check($sformatf("d%0d_release", d), 32'(ar), 32'(er));
            check($sformatf("d%0d_held", d),   32'(ah),  32'(eh));
            for (int k = 0; k < c_nk[d]; k++) begin
                if (ap[k]) pc_press[d][k]++;
                if (ar[k]) pc_rel[d][k]++;
            end
        end
    endtask

    task automatic clear_counts();
        for (int d = 0; d < 3; d++)
            for (int k = 0; k < 18; k++) begin
                pc_press[d][k] = 0; pc_rel[d][k] = 0;
            end
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset(); else model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Reset asserted away from the clock edge to exercise the async clear.
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("async_stable_a", 32'(stable_a), 32'hF);
        check("async_held_a", 32'(held_a), 32'h0);
        run(n);
        rst_n = 1'b1;
    endtask

    initial begin
        bit found;
        rst_n = 1'b0;
        raw_a = 4'hF; raw_b = 4'hF; raw_c = '0;
        model_reset();
        clear_counts();
        run(3);
        check("rst_stable_a", 32'(stable_a), 32'hF);
        check("rst_stable_c", 32'(stable_c), 32'h0);
        check("rst_press_a", 32'(press_a), 32'h0);
        rst_n = 1'b1;
        run(4);

        // Reset in the middle of a press wait: nothing must come out.
        raw_a[0] = 1'b0;
        run(8);
        do_reset(2);
        raw_a = 4'hF;
        clear_counts();
        run(14);
        check("rst_mid_wait_pulses", 32'(pc_press[0][0]), 32'd0);

        // Single press/release latency.
        raw_a[0] = 1'b0;
        run(10);
        check("lat_press_early", 32'(press_a), 32'h0);
        step();
        check("lat_press", 32'(press_a), 32'h1);
        check("lat_stable", 32'(stable_a), 32'hE);
        step();
        check("lat_press_width", 32'(press_a), 32'h0);
        check("lat_held", 32'(held_a), 32'h1);
        raw_a[0] = 1'b1;
        run(10);
        check("lat_rel_early", 32'(rel_a), 32'h0);
        step();
        check("lat_release", 32'(rel_a), 32'h1);
        check("lat_rel_stable", 32'(stable_a), 32'hF);
        run(3);

        // Bounce rejection then a clean press.
        clear_counts();
        raw_a[1] = 1'b0; run(5);
        raw_a[1] = 1'b1; run(1);
        raw_a[1] = 1'b0; run(5);
        raw_a[1] = 1'b1; run(12);
        check("bounce_pulses", 32'(pc_press[0][1]), 32'd0);
        check("bounce_stable", 32'(stable_a), 32'hF);
        raw_a[1] = 1'b0; run(12);
        check("bounce_accept", 32'(held_a), 32'h2);
        raw_a[1] = 1'b1; run(12);

        // Simultaneous keys, partial release, reset while held.
        raw_a = 4'h0;
        run(10);
        step();
        check("multi_press", 32'(press_a), 32'hF);
        run(3);
        raw_a = 4'hA;
        run(10);
        step();
        check("multi_release", 32'(rel_a), 32'hA);
        run(2);
        do_reset(2);
        run(10);
        step();
        check("reaccept_after_reset", 32'(press_a), 32'h5);
        raw_a = 4'hF;
        run(12);

        // Auto-repeat on key 2 of the repeat-enabled instance.
        raw_b[2] = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (press_b[2]) found = 1;
        end
        check("rpt_accept_seen", 32'(found), 32'd1);
        clear_counts();
        run(60);
        check("rpt_count_60", 32'(pc_press[1][2]), 32'd7);
        clear_counts();
        raw_b[2] = 1'b1; run(3);
        raw_b[2] = 1'b0; run(40);
        check("glitch_no_release", 32'(pc_rel[1][2]), 32'd0);
        raw_b[2] = 1'b1; run(12);

        // Switch-style instance: 18 bits, active-high.
        raw_c[1] = 1'b1;
        run(10);
        check("sw_stable_early", 32'(stable_c), 32'h0);
        step();
        check("sw_stable", 32'(stable_c), 32'h2);
        check("sw_press", 32'(press_c), 32'h2);
        raw_c[1] = 1'b0;
        run(12);

        // Random bouncing on every channel, with one reset in the middle.
        for (int cyc = 0; cyc < 1600; cyc++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 15) == 0) raw_a[k] = ~raw_a[k];
                if ($urandom_range(0, 39) == 0) raw_b[k] = ~raw_b[k];
            end
            for (int k = 0; k < 18; k++)
                if ($urandom_range(0, 23) == 0) raw_c[k] = ~raw_c[k];
            if (cyc == 800) do_reset(3);
            else step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_debouncer.md
Name: key_debouncer

Overview:
- Debounces the raw DE2 push-button inputs (KEY[3:0]) before they reach the Qsys system.
- stable_out drives key_cond_export directly, so the PIO only ever sees clean, synchronised levels.
- Also produces single-cycle press/release pulses per key, with optional auto-repeat while a key is held, for local logic and future interrupt use.

Parameters:
- NUM_KEYS, 4: number of independent key channels.
- DEBOUNCE_CYCLES, 500000: cycles the synchronised input must stay constant before it is accepted (10 ms at 50 MHz); minimum 2.
- ACTIVE_LOW, 1: 1 = raw input reads 0 when pressed (DE2 KEY); 0 = pressed reads 1.
- REPEAT_EN, 0: 1 enables auto-repeat press pulses while held.
- HOLD_CYCLES, 25000000: held cycles after acceptance before the first repeat pulse (500 ms).
- REPEAT_CYCLES, 5000000: cycles between subsequent repeat pulses (100 ms).

Ports:
- clk_clk  input  1  system clock (50 MHz).
- reset_reset_n  input  1  asynchronous, active-low reset.
- raw_in  input  NUM_KEYS  asynchronous raw key pins.
- stable_out  output  NUM_KEYS  debounced level, same polarity as raw_in; feeds key_cond_export.
- press_pulse  output  NUM_KEYS  active-high, 1 cycle, on accepted press and on each repeat.
- release_pulse  output  NUM_KEYS  active-high, 1 cycle, on accepted release.
- held  output  NUM_KEYS  active-high, 1 while the debounced state is pressed.

Behaviour:
- Interface: one clock, clk_clk. Reset reset_reset_n is asynchronous and active-low. All flops clear on reset assertion, with no dependence on the clock.
- Reset values:
  - synchroniser flops = released level (all 1s when ACTIVE_LOW=1);
  - stable_out = released level;
  - press_pulse = 0, release_pulse = 0, held = 0;
  - FSM = RELEASED, all counters = 0.
- Synchroniser: two-flop chain per bit, giving s. Internally p = s XOR ACTIVE_LOW (1 = pressed).
- Per-channel FSM, states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT:
  - RELEASED: p=1 -> PRESS_WAIT, cnt=0.
  - PRESS_WAIT:
    - p=0 -> RELEASED, cnt=0, no pulse (bounce rejected).
    - p=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED. stable_out takes the pressed level, held=1 and press_pulse=1 in the same cycle, rpt=0.
    - otherwise cnt+1.
  - PRESSED:
    - p=0 -> RELEASE_WAIT, cnt=0. Repeat counter rpt is frozen and held stays 1.
    - REPEAT_EN=1: rpt counts. On reaching HOLD_CYCLES-1 (first repeat) or REPEAT_CYCLES-1 (subsequent repeats), emit press_pulse for 1 cycle and reset rpt to 0. A flag tracks first vs subsequent repeat.
  - RELEASE_WAIT:
    - p=1 -> PRESSED, cnt=0. rpt resumes; no extra pulse.
    - p=0 and cnt==DEBOUNCE_CYCLES-1 -> RELEASED. stable_out takes the released level, held=0 and release_pulse=1 in the same cycle.
    - otherwise cnt+1.
- Latency: if raw changes and is first sampled at edge N and held constant, stable_out/pulse update at edge N+DEBOUNCE_CYCLES+2.
- Any opposite sample during a WAIT state discards progress; no partial credit.
- Counter widths:
  - cnt: $clog2(DEBOUNCE_CYCLES).
  - rpt: $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)).
  - Neither counter may wrap: each is cleared on every transition.
- Channels are fully independent. Simultaneous edges on several keys produce simultaneous pulses.
- Pulses are never wider than 1 cycle. press_pulse and release_pulse are never both high on one channel.
- Reset mid-operation (any state, any count) returns the channel to RELEASED with no pulse. A key physically held through reset is re-accepted as a fresh press after DEBOUNCE_CYCLES+2 edges.
- All outputs are registered; no combinational path from raw_in.

Decomposition:
- Package key_debouncer_pkg:
  - state enum (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT);
  - function for counter width (clog2 of max).
- Sub-module key_debounce_channel: one bit, containing synchroniser, FSM and counters. key_debouncer is a generate loop of NUM_KEYS instances.

Test Plan:
All tests use DEBOUNCE_CYCLES=8, HOLD_CYCLES=20, REPEAT_CYCLES=6 and ACTIVE_LOW=1 unless stated.
1. Reset with raw_in=4'hF -> stable_out=4'hF, pulses 0, held 0. Assert reset mid-PRESS_WAIT (cnt=5) -> outputs stay released, no pulse after release of reset.
2. raw_in[0] 1->0 sampled at edge N, held -> stable_out[0]=0 and press_pulse[0]=1 at edge N+10 for exactly 1 cycle, held[0]=1. Then 0->1 -> release_pulse[0] at +10.
3. Bounce: raw_in[1] toggles low for 5 cycles, high 1 cycle, low 5 cycles, then high -> no pulse, stable_out[1] stays 1. A later low for 8+ stable cycles -> accepted.
4. raw_in = 4'h0 on one edge -> press_pulse = 4'hF on the same single cycle. Release keys 3 and 1 only -> release_pulse = 4'hA.
5. REPEAT_EN=1, key 2 held 60 cycles past acceptance -> press_pulses at acceptance, +20, +26, +32, ... A release glitch of 3 cycles mid-hold -> no release_pulse and the repeat schedule is unshifted by the glitch apart from the frozen cycles.
6. ACTIVE_LOW=0, NUM_KEYS=18 (switch use) -> reset stable_out=0. Input 1 held 10 edges -> stable_out=1 and press_pulse on that bit only.
